// File: rtl/rfPhoenixPkg.sv
// Shared rfPhoenix types and sizing: thread count, register count, memory response record
// and the default depth of the memory response queue.
package rfPhoenixPkg;
  localparam int NTHREADS = 8;
  localparam int NREGS    = 128;
  localparam int MRQ_DEP  = 16;
  localparam int TID_W    = $clog2(NTHREADS);
  localparam int REG_W    = $clog2(NREGS);

  typedef struct packed {
    logic [31:0]      res;
    logic [TID_W-1:0] thread;
    logic [REG_W-1:0] tgt;
    logic             v;
  } MemoryResponse;
endpackage

// File: rtl/rfphoenix_rollback_bitmap.sv
// Per-thread pending-target bitmap. Pop clear, push set and thread clear-all are applied
// in that order within one cycle, so a later event overrides an earlier one.
module rfphoenix_rollback_bitmap #(
  parameter int NTHR = 8,
  parameter int NREG = 128
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    set_en,
  input  logic [$clog2(NTHR)-1:0] set_thread,
  input  logic [$clog2(NREG)-1:0] set_reg,
  input  logic                    clr_en,
  input  logic [$clog2(NTHR)-1:0] clr_thread,
  input  logic [$clog2(NREG)-1:0] clr_reg,
  input  logic                    clr_all_en,
  input  logic [$clog2(NTHR)-1:0] clr_all_thread,
  input  logic [$clog2(NTHR)-1:0] sel_thread,
  output logic [NREG-1:0]         sel_bitmap
);
  logic [NREG-1:0] bits [NTHR];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NTHR; i++) bits[i] <= '0;
    end else begin
      if (clr_en)     bits[clr_thread][clr_reg] <= 1'b0;
      if (set_en)     bits[set_thread][set_reg] <= 1'b1;
      if (clr_all_en) bits[clr_all_thread]      <= '0;
    end
  end

  assign sel_bitmap = bits[sel_thread];
endmodule

// File: rtl/rfphoenix_mem_resp_queue.sv
// First-word-fall-through memory response queue with per-thread rollback; entries killed
// by rollback are dropped from the head one per cycle so the consumer never sees them.
// Handshake: an entry is transferred when rd=1 and dv=1 in the same cycle; rd with dv=0 is ignored.
module rfphoenix_mem_resp_queue
  import rfPhoenixPkg::*;
#(
  parameter int DEP   = MRQ_DEP,
  parameter int NTHR  = NTHREADS,
  parameter int NREG  = NREGS,
  parameter int AFULL = DEP - 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr,
  input  MemoryResponse           di,
  input  logic                    rd,
  output MemoryResponse           dout,
  output logic                    dv,
  output logic [$clog2(DEP):0]    cnt,
  output logic                    full,
  output logic                    afull,
  output logic                    empty,
  output logic                    ovf,
  input  logic                    rollback,
  input  logic [$clog2(NTHR)-1:0] rollback_thread,
  output logic [NREG-1:0]         rollback_bitmap
);
  localparam int AW = $clog2(DEP);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEP_C   = PW'(DEP);
  localparam logic [PW-1:0] AFULL_C = PW'(AFULL);
  localparam logic [PW-1:0] ONE     = PW'(1);

  MemoryResponse mem [DEP];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          pop, purge, push_ok;
  MemoryResponse push_ent;

  assign cnt   = wr_ptr - rd_ptr;
  assign empty = (cnt == '0);
  assign full  = (cnt == DEP_C);
  assign afull = (cnt >= AFULL_C);
  assign dout  = mem[rd_ptr[AW-1:0]];
  assign dv    = !empty && dout.v;

  // Invalid head entries are skipped regardless of rd; a full queue only takes a push
  // when a real pop frees the slot in the same cycle.
  assign pop     = rd && dv;
  assign purge   = !empty && !dout.v;
  assign push_ok = wr && (!full || pop);

  always_comb begin
    push_ent   = di;
    push_ent.v = di.v && !(rollback && (di.thread == rollback_thread));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < DEP; i++) mem[i].v <= 1'b0;
    end else begin
      if (wr && full && !pop) ovf <= 1'b1;
      if (pop || purge) rd_ptr <= rd_ptr + ONE;
      if (rollback) begin
        for (int i = 0; i < DEP; i++)
          if (mem[i].thread == rollback_thread) mem[i].v <= 1'b0;
      end
      // Written after the rollback sweep so the new entry's own kill bit wins for its slot.
      if (push_ok) begin
        mem[wr_ptr[AW-1:0]] <= push_ent;
        wr_ptr              <= wr_ptr + ONE;
      end
    end
  end

  // Entries stored already invalid never reach the consumer, so they never mark a target pending.
  rfphoenix_rollback_bitmap #(
    .NTHR (NTHR),
    .NREG (NREG)
  ) u_bitmap (
    .clk            (clk),
    .rst_n          (rst_n),
    .set_en         (push_ok && di.v),
    .set_thread     (di.thread),
    .set_reg        (di.tgt),
    .clr_en         (pop),
    .clr_thread     (dout.thread),
    .clr_reg        (dout.tgt),
    .clr_all_en     (rollback),
    .clr_all_thread (rollback_thread),
    .sel_thread     (rollback_thread),
    .sel_bitmap     (rollback_bitmap)
  );
endmodule

// File: tb/tb_rfphoenix_mem_resp_queue.sv
// Bench for the memory response queue: directed scenarios plus random traffic, checked
// against a queue-and-array reference model of the response stream and pending bitmaps.
module tb_rfphoenix_mem_resp_queue;
  import rfPhoenixPkg::*;

  localparam int DEP = MRQ_DEP;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr = 1'b0;
  MemoryResponse di = '0;
  logic          rd = 1'b0;
  MemoryResponse dout;
  logic          dv;
  logic [4:0]    cnt;
  logic          full, afull, empty, ovf;
  logic          rollback = 1'b0;
  logic [2:0]    rollback_thread = '0;
  logic [127:0]  rollback_bitmap;

  int checks = 0;
  int errors = 0;

  MemoryResponse exp_q[$];
  logic [127:0]  exp_bm [NTHREADS];
  logic          exp_ovf;

  rfphoenix_mem_resp_queue dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr              (wr),
    .di              (di),
    .rd              (rd),
    .dout            (dout),
    .dv              (dv),
    .cnt             (cnt),
    .full            (full),
    .afull           (afull),
    .empty           (empty),
    .ovf             (ovf),
    .rollback        (rollback),
    .rollback_thread (rollback_thread),
    .rollback_bitmap (rollback_bitmap)
  );

  // clock/reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic m_dv;
    m_dv = (exp_q.size() != 0) && exp_q[0].v;
    check("cnt",   128'(cnt),   128'(exp_q.size()));
    check("full",  128'(full),  128'(exp_q.size() == DEP));
    check("afull", 128'(afull), 128'(exp_q.size() >= DEP - 4));
    check("empty", 128'(empty), 128'(exp_q.size() == 0));
    check("dv",    128'(dv),    128'(m_dv));
    check("ovf",   128'(ovf),   128'(exp_ovf));
    check("bitmap", rollback_bitmap, exp_bm[rollback_thread]);
    if (m_dv) check("dout", 128'(dout), 128'(exp_q[0]));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; wr = 1'b0; rd = 1'b0; rollback = 1'b0;
    @(posedge clk); #1;
    exp_q.delete();
    for (int t = 0; t < NTHREADS; t++) exp_bm[t] = '0;
    exp_ovf = 1'b0;
    rst_n = 1'b1;
    check_outputs();
  endtask

  // driver: one clock of stimulus, then advance the reference model and compare
  task automatic cycle(input logic w, input MemoryResponse d, input logic r,
                       input logic rb, input logic [2:0] rbt);
    logic m_empty, m_full, m_dv, m_pop, m_purge, m_acc;
    MemoryResponse h, e;
    wr = w; di = d; rd = r; rollback = rb; rollback_thread = rbt;
    m_empty = (exp_q.size() == 0);
    m_full  = (exp_q.size() == DEP);
    m_dv    = !m_empty && exp_q[0].v;
    h       = m_empty ? '0 : exp_q[0];
    m_pop   = r && m_dv;
    m_purge = !m_empty && !h.v;
    m_acc   = w && (!m_full || m_pop);
    if (w && m_full && !m_pop) exp_ovf = 1'b1;
    @(posedge clk); #1;
    if (m_pop) exp_bm[h.thread][h.tgt] = 1'b0;
    if (m_acc && d.v) exp_bm[d.thread][d.tgt] = 1'b1;
    if (rb) exp_bm[rbt] = '0;
    if (m_pop || m_purge) void'(exp_q.pop_front());
    if (rb) begin
      for (int i = 0; i < exp_q.size(); i++) begin
        e = exp_q[i];
        if (e.thread == rbt) begin
          e.v = 1'b0;
          exp_q[i] = e;
        end
      end
    end
    if (m_acc) begin
      e = d;
      if (rb && d.thread == rbt) e.v = 1'b0;
      exp_q.push_back(e);
    end
    check_outputs();
  endtask

  function automatic MemoryResponse mk(input int t, input int g);
    MemoryResponse m;
    m.res    = $urandom;
    m.thread = TID_W'(t);
    m.tgt    = REG_W'(g);
    m.v      = 1'b1;
    return m;
  endfunction

  task automatic idle(input int n, input logic [2:0] rbt);
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0, rbt);
  endtask

  initial begin
    do_reset();

    // fill to full, then one overflowing push
    for (int i = 0; i < DEP + 1; i++)
      cycle(1'b1, mk($urandom_range(0, 7), $urandom_range(0, 127)), 1'b0, 1'b0, 3'(i));
    idle(2, 3'd0);
    do_reset();

    // FWFT order and bitmap bookkeeping
    cycle(1'b1, mk(2, 5), 1'b0, 1'b0, 3'd2);
    cycle(1'b1, mk(3, 9), 1'b0, 1'b0, 3'd2);
    cycle(1'b0, '0, 1'b1, 1'b0, 3'd2);
    idle(1, 3'd2);
    idle(1, 3'd3);
    do_reset();

    // rollback purge of thread 1 around a thread-4 survivor
    cycle(1'b1, mk(1, 10), 1'b0, 1'b0, 3'd1);
    cycle(1'b1, mk(1, 11), 1'b0, 1'b0, 3'd1);
    cycle(1'b1, mk(4, 12), 1'b0, 1'b0, 3'd1);
    cycle(1'b1, mk(1, 13), 1'b0, 1'b0, 3'd1);
    cycle(1'b0, '0, 1'b0, 1'b1, 3'd1);
    idle(2, 3'd4);
    cycle(1'b0, '0, 1'b1, 1'b0, 3'd4);
    idle(2, 3'd1);

    // rollback with a same-cycle push of the same thread
    cycle(1'b1, mk(6, 7), 1'b0, 1'b1, 3'd6);
    idle(2, 3'd6);

    // steady push/pop across the pointer wrap
    for (int i = 0; i < 3; i++) cycle(1'b1, mk(i, 20 + i), 1'b0, 1'b0, 3'd0);
    for (int i = 0; i < 40; i++)
      cycle(1'b1, mk($urandom_range(0, 7), $urandom_range(0, 127)), 1'b1, 1'b0, 3'(i));

    // reset mid-stream
    do_reset();
    for (int i = 0; i < 9; i++) cycle(1'b1, mk(i % 8, i), 1'b0, 1'b0, 3'd0);
    do_reset();
    for (int t = 0; t < NTHREADS; t++) idle(1, 3'(t));

    // random traffic
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(0, 99) < 60,
            mk($urandom_range(0, 7), $urandom_range(0, 127)),
            $urandom_range(0, 99) < 50,
            $urandom_range(0, 99) < 6,
            3'($urandom_range(0, 7)));
    idle(DEP + 2, 3'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rfphoenix_mem_resp_queue.md
# rfphoenix_mem_resp_queue

Parametrised, first-word-fall-through queue for memory responses returning to the rfPhoenix writeback stage, with per-thread rollback. Tracks a per-thread pending-target bitmap and automatically purges entries invalidated by rollback, so the consumer never sees a killed response. True full/empty detection at depth DEP. Overflow is flagged and sticky.

## Interface
- DEP, 16: queue depth; power of two, ≥4
- NTHR, NTHREADS: thread count; power of two
- NREG, 128: architectural target registers per thread
- AFULL, DEP-4: almost-full threshold in entries
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  reset; synchronous, active-low
- wr  in  1  push di this cycle
- di  in  MemoryResponse  response; uses fields thread, tgt, v
- rd  in  1  pop head; honoured only when dv=1
- dout  out  MemoryResponse  head entry; combinational from storage
- dv  out  1  head present and valid
- cnt  out  $clog2(DEP)+1  occupancy, 0..DEP
- full  out  1  cnt==DEP
- afull  out  1  cnt>=AFULL
- empty  out  1  cnt==0
- ovf  out  1  sticky; set on push while full
- rollback  in  1  invalidate all entries of rollback_thread
- rollback_thread  in  $clog2(NTHR)  thread to roll back / bitmap select
- rollback_bitmap  out  NREG  pending-target bitmap of rollback_thread, combinational

## Operation
- Pointers: wr_ptr, rd_ptr, $clog2(DEP)+1 bits each (extra wrap bit); cnt = wr_ptr - rd_ptr modulo 2^($clog2(DEP)+1).
- Push (wr & !full): mem[wr_ptr] <= di; wr_ptr+1; bitmaps[di.thread][di.tgt] <= 1.
- Push when full and no pop in the same cycle: data dropped, pointers unchanged, ovf <= 1. Only reset clears ovf.
- Push when full with a pop in the same cycle: push accepted.
- Pop (rd & dv): rd_ptr+1; bitmaps[dout.thread][dout.tgt] <= 0.
- rd with dv=0: ignored.
- Purge: when !empty and head entry v==0, rd_ptr+1 in that cycle, regardless of rd; bitmap untouched. One entry purged per cycle.
- dv = !empty & mem[rd_ptr].v.
- Rollback:
  - Every stored entry with thread==rollback_thread gets v <= 0.
  - bitmaps[rollback_thread] <= 0.
  - A same-cycle push of that thread is stored with v=0 and does not set its bitmap bit.
- Simultaneous events (priority, later overrides earlier): pop clear, then push set, then rollback clear.
  - A push and a pop hitting the same bitmap bit leaves it set.
- Same-cycle push and pop when empty: impossible, since dv=0.
- Reset (rst_n=0 at an edge):
  - Pointers 0, all bitmaps 0, all mem v bits 0, ovf 0.
  - Outputs: cnt=0, empty=1, full=0, afull=0, dv=0, rollback_bitmap=0.
  - Reset mid-stream discards all contents.

## Timing
- Push to head visible: dv high the cycle after the wr edge into an empty queue. Latency 1.
- Pop: dout advances to the next entry in the cycle after the rd edge.
- Rollback effect on dv/dout: head v cleared at the edge; a purge begins the following cycle. Purge of k killed entries takes k cycles.
- cnt, full, afull, empty: derived combinationally from registered pointers, so they update one cycle after the event.
- rollback_bitmap: reflects updates one cycle after the edge that caused them. The rollback_thread select acts combinationally.
- Wrap-around: pointer index bits wrap at DEP; the extra bit toggles, so full and empty stay distinct.

## Structure
- Shared package rfPhoenixPkg:
  - MemoryResponse (thread, tgt, v fields).
  - NTHREADS.
  - Add NREGS=128 and MRQ_DEP=16 there.
- Sub-module rfphoenix_rollback_bitmap:
  - NTHR×NREG register array.
  - Ports: set (thread, reg), clear (thread, reg), clear-all (thread), read select.
  - Implements the priority rules above.
- Queue storage and pointer logic stay in the top module.

## Test plan
- Fill without reads: 16 pushes with DEP=16 → cnt=16, full=1, afull set from the 12th push. 17th push → ovf=1, data dropped, cnt stays 16.
- FWFT order: push thread 2/tgt 5, then thread 3/tgt 9. dv=1 the next cycle with dout.tgt=5. rd → dout.tgt=9 next cycle. bitmaps[2][5]=0 and bitmaps[3][9]=1.
- Rollback purge: queue holds threads 1,1,4,1. Assert rollback with thread 1 → rollback_bitmap=0 next cycle. Head purged over 2 cycles, then dout.thread=4 with dv=1; the trailing thread-1 entry is purged after that pop.
- Simultaneous: rollback thread 6 with a same-cycle push of thread 6/tgt 7 → entry stored invalid, bitmaps[6][7]=0, and it is purged without ever asserting dv.
- Wrap: run 40 push/pop pairs at cnt=3 steady → cnt constant, data order preserved across the pointer wrap bit.
- Reset mid-stream: rst_n=0 with cnt=9 → next cycle cnt=0, empty=1, dv=0, ovf=0, all bitmaps 0.
